// File: rtl/stage_if_fetch_if.sv
// Bundle of the fetch stage's external signals: the instruction-ROM
// request/ready bus, the decode-side control (stall, redirect) and the
// if/id boundary outputs.
//   master : the fetch stage (drives rom_request/rom_address and if_*)
//   slave  : ROM plus decode/hazard side (drives rom_ready/rom_data,
//            stall and the pc_write redirect)
interface stage_if_fetch_if;
   logic        stall;
   logic        pc_write_enable;
   logic [31:0] pc_write_data;
   logic        rom_request;
   logic [31:0] rom_address;
   logic        rom_ready;
   logic [31:0] rom_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;

   modport master (
      input  stall, pc_write_enable, pc_write_data, rom_ready, rom_data,
      output rom_request, rom_address, if_valid, if_pc, if_instruction
   );

   modport slave (
      output stall, pc_write_enable, pc_write_data, rom_ready, rom_data,
      input  rom_request, rom_address, if_valid, if_pc, if_instruction
   );
endinterface

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage. Owns the fetch PC, issues word fetches to the
// instruction ROM over a request/ready handshake and buffers the returned
// words in a small prefetch FIFO whose head is shown at the if/id boundary.
// A redirect from decode flushes the FIFO and kills any in-flight fetch.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : stage_if_fetch_if.master
//            in : stall, pc_write_enable, pc_write_data, rom_ready, rom_data
//            out: rom_request, rom_address, if_valid, if_pc, if_instruction
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal fetch; request whenever the FIFO has room
// ST_DRAIN | redirect hit an outstanding request; hold it until the ROM
//          | answers, drop that word, then resume at the pending target
module stage_if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic             clock,
   input  logic             reset,
   stage_if_fetch_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t         state, state_nxt;
   logic [31:0]    fetch_pc, fetch_pc_nxt;
   logic [31:0]    pending_pc, pending_pc_nxt;
   logic [CW-1:0]  count, count_nxt;
   logic [PW-1:0]  rd_ptr, rd_ptr_nxt;
   logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
   logic [31:0]    pc_mem  [DEPTH];
   logic [31:0]    ins_mem [DEPTH];

   logic           req;
   logic           enq;
   logic           deq;
   logic           head_valid;
   logic [31:0]    target;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_RUN;
         fetch_pc   <= RESET_PC;
         pending_pc <= RESET_PC;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         fetch_pc   <= fetch_pc_nxt;
         pending_pc <= pending_pc_nxt;
         count      <= count_nxt;
         rd_ptr     <= rd_ptr_nxt;
         wr_ptr     <= wr_ptr_nxt;
      end
   end

   // Storage needs no reset: nothing is visible unless count says so.
   always_ff @(posedge clock) begin
      if (!reset && enq) begin
         pc_mem[wr_ptr]  <= fetch_pc;
         ins_mem[wr_ptr] <= bus.rom_data;
      end
   end

   always_comb begin
      state_nxt      = state;
      fetch_pc_nxt   = fetch_pc;
      pending_pc_nxt = pending_pc;
      count_nxt      = count;
      rd_ptr_nxt     = rd_ptr;
      wr_ptr_nxt     = wr_ptr;
      enq            = 1'b0;
      deq            = 1'b0;
      target         = {bus.pc_write_data[31:2], 2'b00};
      head_valid     = (count != '0);

      // Count only rises via a completed request, so a raised request can
      // only fall after its own rom_ready.
      req = (state == ST_DRAIN) || (count < DEPTH_C);

      if (bus.pc_write_enable) begin
         count_nxt  = '0;
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         if (!req || bus.rom_ready) begin
            fetch_pc_nxt = target;
            state_nxt    = ST_RUN;
         end else begin
            pending_pc_nxt = target;
            state_nxt      = ST_DRAIN;
         end
      end else if (state == ST_DRAIN) begin
         if (bus.rom_ready) begin
            fetch_pc_nxt = pending_pc;
            state_nxt    = ST_RUN;
         end
      end else begin
         enq = req && bus.rom_ready;
         deq = head_valid && !bus.stall;
         if (enq) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            wr_ptr_nxt   = wr_ptr + PW'(1);
         end
         if (deq) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
         end
         count_nxt = count + CW'(enq) - CW'(deq);
      end

      // Outputs are forced to their idle values for the whole reset cycle,
      // not just after the first reset edge.
      bus.rom_request    = !reset && req;
      bus.rom_address    = reset ? RESET_PC : fetch_pc;
      bus.if_valid       = !reset && head_valid;
      bus.if_pc          = (!reset && head_valid) ? pc_mem[rd_ptr]  : 32'h0;
      bus.if_instruction = (!reset && head_valid) ? ins_mem[rd_ptr] : 32'h0;
   end

endmodule

// File: tb/tb_stage_if_fetch.sv
module tb_stage_if_fetch;

   logic clock;
   logic reset;
   stage_if_fetch_if bus ();

   stage_if_fetch #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Zero-latency ROM model: every word encodes its own address.
   assign bus.rom_data = bus.rom_address | 32'hA000_0000;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          assertions = 0;
   int          failures   = 0;
   logic [63:0] exp_q [$];
   logic [63:0] mon_e;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      assertions++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back({pc, pc | 32'hA000_0000});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_drain(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
      check32("drain_complete", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Scoreboard monitor: pops on every real dequeue, plus handshake stability.
   always @(negedge clock) begin
      if (!reset && bus.if_valid && !bus.stall && !bus.pc_write_enable) begin
         if (exp_q.size() == 0) begin
            assertions++;
            failures++;
            $display("FAIL unexpected_output: got pc %h instr %h, required no output", bus.if_pc, bus.if_instruction);
         end else begin
            mon_e = exp_q.pop_front();
            check32("if_pc", bus.if_pc, mon_e[63:32]);
            check32("if_instruction", bus.if_instruction, mon_e[31:0]);
         end
      end
      if (!reset && prev_hold) begin
         check32("req_held", {31'h0, bus.rom_request}, 32'd1);
         check32("addr_held", bus.rom_address, prev_addr);
      end
      prev_hold = !reset && bus.rom_request && !bus.rom_ready;
      prev_addr = bus.rom_address;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset               = 1'b1;
      bus.stall           = 1'b0;
      bus.pc_write_enable = 1'b0;
      bus.pc_write_data   = 32'h0;
      bus.rom_ready       = 1'b1;

      // Reset state
      repeat (2) tick();
      @(negedge clock);
      check32("rst_rom_request", {31'h0, bus.rom_request}, 32'd0);
      check32("rst_rom_address", bus.rom_address, 32'h0);
      check32("rst_if_valid", {31'h0, bus.if_valid}, 32'd0);
      check32("rst_if_pc", bus.if_pc, 32'h0);
      check32("rst_if_instruction", bus.if_instruction, 32'h0);

      // Zero-wait sequential fetch
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
      tick();
      reset = 1'b0;
      @(negedge clock);
      check32("seq_first_request", {31'h0, bus.rom_request}, 32'd1);
      check32("seq_first_address", bus.rom_address, 32'h0);
      check32("seq_first_valid", {31'h0, bus.if_valid}, 32'd0);
      wait_drain(20);
      bus.stall = 1'b1;

      // Stall until full, then release
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      check32("full_request", {31'h0, bus.rom_request}, 32'd0);
      check32("full_valid", {31'h0, bus.if_valid}, 32'd1);
      check32("full_head_pc", bus.if_pc, 32'h0);
      check32("full_head_instr", bus.if_instruction, 32'hA000_0000);
      tick();
      @(negedge clock);
      check32("stall_head_pc", bus.if_pc, 32'h0);
      check32("stall_request", {31'h0, bus.rom_request}, 32'd0);
      tick();
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      bus.stall = 1'b0;
      wait_drain(20);
      bus.stall = 1'b1;

      // Redirect with no request in flight
      repeat (3) tick();
      @(negedge clock);
      check32("c_full_request", {31'h0, bus.rom_request}, 32'd0);
      check32("c_head_pc", bus.if_pc, 32'hC);
      tick();
      bus.pc_write_enable = 1'b1;
      bus.pc_write_data   = 32'h8;
      tick();
      bus.pc_write_enable = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      check32("c_refill_head", bus.if_pc, 32'h8);
      check32("c_refill_request", {31'h0, bus.rom_request}, 32'd0);
      tick();
      bus.pc_write_enable = 1'b1;
      bus.pc_write_data   = 32'h0000_0103;
      tick();
      bus.pc_write_enable = 1'b0;
      push_exp(32'h100); push_exp(32'h104);
      bus.stall = 1'b0;
      @(negedge clock);
      check32("c_flush_valid", {31'h0, bus.if_valid}, 32'd0);
      check32("c_new_request", {31'h0, bus.rom_request}, 32'd1);
      check32("c_new_address", bus.rom_address, 32'h100);
      wait_drain(20);
      bus.stall = 1'b1;

      // Redirect while ROM is waiting
      repeat (3) tick();
      bus.rom_ready       = 1'b0;
      bus.pc_write_enable = 1'b1;
      bus.pc_write_data   = 32'h10;
      tick();
      bus.pc_write_data = 32'h200;
      @(negedge clock);
      check32("d_w1_request", {31'h0, bus.rom_request}, 32'd1);
      check32("d_w1_address", bus.rom_address, 32'h10);
      check32("d_w1_valid", {31'h0, bus.if_valid}, 32'd0);
      tick();
      bus.pc_write_enable = 1'b0;
      @(negedge clock);
      check32("d_w2_address", bus.rom_address, 32'h10);
      tick();
      @(negedge clock);
      check32("d_w3_address", bus.rom_address, 32'h10);
      tick();
      bus.rom_ready = 1'b1;
      @(negedge clock);
      check32("d_w4_request", {31'h0, bus.rom_request}, 32'd1);
      check32("d_w4_address", bus.rom_address, 32'h10);
      tick();
      push_exp(32'h200); push_exp(32'h204);
      bus.stall = 1'b0;
      @(negedge clock);
      check32("d_w5_request", {31'h0, bus.rom_request}, 32'd1);
      check32("d_w5_address", bus.rom_address, 32'h200);
      check32("d_w5_valid", {31'h0, bus.if_valid}, 32'd0);
      wait_drain(20);
      bus.stall = 1'b1;

      // Simultaneous redirect, rom_ready and dequeue
      repeat (3) tick();
      bus.pc_write_enable = 1'b1;
      bus.pc_write_data   = 32'h300;
      tick();
      bus.pc_write_enable = 1'b0;
      tick();
      bus.pc_write_enable = 1'b1;
      bus.pc_write_data   = 32'h400;
      bus.stall           = 1'b0;
      @(negedge clock);
      check32("e_head_valid", {31'h0, bus.if_valid}, 32'd1);
      check32("e_head_pc", bus.if_pc, 32'h300);
      check32("e_request", {31'h0, bus.rom_request}, 32'd1);
      check32("e_address", bus.rom_address, 32'h304);
      tick();
      bus.pc_write_enable = 1'b0;
      push_exp(32'h400); push_exp(32'h404);
      @(negedge clock);
      check32("e_flush_valid", {31'h0, bus.if_valid}, 32'd0);
      check32("e_target_address", bus.rom_address, 32'h400);
      wait_drain(20);
      bus.stall = 1'b1;

      // PC wrap
      repeat (3) tick();
      bus.pc_write_enable = 1'b1;
      bus.pc_write_data   = 32'hFFFF_FFFC;
      bus.stall           = 1'b0;
      push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
      tick();
      bus.pc_write_enable = 1'b0;
      wait_drain(20);
      bus.stall     = 1'b1;
      bus.rom_ready = 1'b0;
      @(negedge clock);
      check32("f_pending_request", {31'h0, bus.rom_request}, 32'd1);
      check32("f_pending_address", bus.rom_address, 32'hC);

      // Reset during a pending request, with rom_ready in the reset cycle
      tick();
      reset         = 1'b1;
      bus.rom_ready = 1'b1;
      @(negedge clock);
      check32("r_in_reset_request", {31'h0, bus.rom_request}, 32'd0);
      check32("r_in_reset_valid", {31'h0, bus.if_valid}, 32'd0);
      tick();
      @(negedge clock);
      check32("r_after_request", {31'h0, bus.rom_request}, 32'd0);
      check32("r_after_valid", {31'h0, bus.if_valid}, 32'd0);
      check32("r_after_address", bus.rom_address, 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      check32("r_restart_request", {31'h0, bus.rom_request}, 32'd1);
      check32("r_restart_address", bus.rom_address, 32'h0);
      tick();
      @(negedge clock);
      check32("r_restart_head_pc", bus.if_pc, 32'h0);
      check32("r_restart_head_valid", {31'h0, bus.if_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/stage_if_fetch.md
Name: stage_if_fetch

Overview:
Instruction-fetch stage. It drives the program counter and supplies instructions to the decode stage. It owns the PC that decode reads and accepts decode's pc_write_enable/pc_write_data redirect. It fetches from instruction ROM over a request/ready handshake into a small prefetch FIFO. The FIFO head is presented to the if/id boundary, and consumption is held off while decode or the hazard logic requests a stall.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
DEPTH, 2, prefetch FIFO entries; legal values are 2 and 4.

Ports:
clock  input  1  rising-edge clock
reset  input  1  reset
stall  input  1  consumer hold; head is not dequeued while high
pc_write_enable  input  1  redirect request from decode
pc_write_data  input  32  redirect target; bits [1:0] are ignored and treated as 0
rom_request  output  1  ROM fetch request
rom_address  output  32  ROM word address (byte address, bits [1:0] = 0)
rom_ready  input  1  ROM response valid this cycle for the held request
rom_data  input  32  ROM instruction; sampled only when rom_request && rom_ready
if_valid  output  1  FIFO head valid
if_pc  output  32  PC of head instruction
if_instruction  output  32  head instruction word

Behaviour:
- Reset is synchronous and active-high: reset is synchronous, active-high.
- Reset values: fetch_pc = RESET_PC, FIFO empty (count 0, rd/wr pointers 0), state RUN.
- Output values in reset: rom_request 0, rom_address RESET_PC, if_valid 0, if_pc 0, if_instruction 0.
- Reset mid-handshake abandons the request. A rom_ready in the reset cycle is ignored.
- State RUN:
  - rom_request = (count < DEPTH); rom_address = fetch_pc.
  - Once rom_request is raised, it and rom_address stay stable until rom_ready. A dequeue never lowers it.
  - On rom_request && rom_ready && no redirect: enqueue {fetch_pc, rom_data} and set fetch_pc += 4.
  - Zero-wait ROM: one enqueue per cycle while count < DEPTH.
- State DRAIN: entered on a redirect while rom_request is high and rom_ready is low.
  - rom_request stays high with the old address.
  - The response, when it arrives, is discarded (no enqueue).
  - On rom_ready: go to RUN and set fetch_pc = pending target.
  - A further redirect in DRAIN overwrites the pending target and the state stays DRAIN.
- Redirect (pc_write_enable=1) has top priority in the cycle it is asserted:
  - FIFO flushed (count 0). A same-cycle dequeue is ignored; a same-cycle rom_ready response is discarded.
  - If rom_request is low, or rom_ready is high: fetch_pc = target and state RUN; the next request goes out the following cycle.
  - Otherwise go to DRAIN with the target saved.
- Delay slot: none architecturally. Every buffered or in-flight instruction younger than the redirect is killed.
- Dequeue: occurs when if_valid && !stall && !pc_write_enable.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Enqueue is only possible for a request issued while count < DEPTH, so the FIFO never overflows.
- Outputs: if_valid = (count != 0). if_pc and if_instruction come from the head entry and read 0 when empty. The head is combinational from registered storage.
- Arithmetic: fetch_pc is 32-bit, wrapping 32'hFFFF_FFFC + 4 = 32'h0000_0000. Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Stall while full: rom_request stays 0 and the FIFO holds its contents. No fetch_pc change except by redirect.

Test Plan:
- Zero-wait sequential fetch, RESET_PC=0, rom_ready=1, rom_data=addr|0xA000_0000, stall=0 -> rom_request goes high the first cycle after reset. The first valid entry appears one cycle after that: if_valid=1, if_pc=0, if_instruction=0xA000_0000. Entries then follow one per cycle at PC 4, 8, 12.
- Stall with DEPTH=2 held for 5 cycles -> FIFO fills to 2 and rom_request drops to 0. Head stays PC 0, not advancing. On release, PCs 0 and 4 are delivered in order with no gap or duplicate.
- Redirect with no request in flight: pc_write_enable=1, pc_write_data=0x0000_0103 while FIFO holds PCs 8 and 12 -> next cycle if_valid=0. The following request has rom_address=0x100, then if_pc=0x100.
- Redirect while the ROM is waiting: rom_ready held 0 for 3 cycles on addr 0x10, redirect to 0x200 in the first cycle, then rom_ready=1 -> no enqueue for 0x10, and the 0x10 address stays stable until ready. The next request is for 0x200.
- Simultaneous redirect, rom_ready and dequeue in one cycle -> the response is dropped and the head is not consumed. The FIFO is empty next cycle and the next fetch is at the target.
- Wrap and reset: redirect to 0xFFFF_FFFC with zero-wait ROM -> if_pc sequence 0xFFFF_FFFC, 0x0000_0000. Asserting reset during a pending rom_request -> the next cycle shows rom_request=0, if_valid=0, rom_address=RESET_PC.
